// File: rtl/bus_iface_if.sv
// bus_iface_if: CPU-side request/response and motherboard REQ/ACK bus signals.
// master is the bus_iface unit, slave is the CPU/motherboard environment around it.
interface bus_iface_if #(parameter int width = 32);
    logic             cpu_req;
    logic             cpu_we;
    logic [width-1:0] cpu_addr;
    logic [width-1:0] cpu_wdata;
    logic             cpu_busy;
    logic             cpu_done;
    logic             cpu_err;
    logic [width-1:0] cpu_rdata;
    logic [width-1:0] mobo_ctrl;
    logic [width-1:0] mobo_stat;
    logic [width-1:0] addr;
    logic [width-1:0] data_out;
    logic [width-1:0] data_in;
    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mobo_stat, data_in,
        output cpu_busy, cpu_done, cpu_err, cpu_rdata, mobo_ctrl, addr, data_out
    );
    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mobo_stat, data_in,
        input  cpu_busy, cpu_done, cpu_err, cpu_rdata, mobo_ctrl, addr, data_out
    );
endinterface

// File: rtl/bus_iface.sv
// bus_iface: single-word CPU read/write over a four-phase REQ/ACK motherboard bus.
// Every output comes from a register; busy/done are decodes of the state register.
module bus_iface #(
    parameter int width   = 32,
    parameter int TIMEOUT = 255
) (
    input logic         clk,
    input logic         rst,
    bus_iface_if.master b
);
    typedef enum logic [1:0] {IDLE, ASSERT, RELEASE, DONE} state_t;
    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);
    state_t           state_q, state_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic [width-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             ack, unused_stat;
    assign ack         = b.mobo_stat[0];
    assign unused_stat = ^b.mobo_stat[width-1:2];
    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = (state_q == ASSERT || state_q == RELEASE) ? cnt_q + 16'd1 : '0;
        case (state_q)
            IDLE: if (b.cpu_req) begin
                addr_d  = b.cpu_addr;
                wdata_d = b.cpu_wdata;
                ctrl_d  = {b.cpu_we, 1'b1};
                state_d = ASSERT;
            end
            // ACK is tested first so it wins over a coincident terminal count
            ASSERT: if (ack) begin
                ctrl_d[0] = 1'b0;
                err_d     = b.mobo_stat[1];
                rdata_d   = (!ctrl_q[1] && !b.mobo_stat[1]) ? b.data_in : rdata_q;
                cnt_d     = '0;
                state_d   = RELEASE;
            end else if (cnt_q == LAST) begin
                ctrl_d[0] = 1'b0;
                err_d     = 1'b1;
                state_d   = DONE;
            end
            RELEASE: if (!ack) begin
                state_d = DONE;
            end else if (cnt_q == LAST) begin
                err_d   = 1'b1;
                state_d = DONE;
            end
            default: begin
                ctrl_d[1] = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    assign b.cpu_busy  = state_q != IDLE;
    assign b.cpu_done  = state_q == DONE;
    assign b.cpu_err   = err_q;
    assign b.cpu_rdata = rdata_q;
    assign b.mobo_ctrl = {{(width-2){1'b0}}, ctrl_q};
    assign b.addr      = addr_q;
    assign b.data_out  = wdata_q;
endmodule

// File: tb/tb_bus_iface.sv
// tb_bus_iface: directed scenarios for bus_iface with TIMEOUT = 8; the bench plays CPU and bus.
module tb_bus_iface;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    bus_iface_if #(.width(32)) b ();
    bus_iface #(.width(32), .TIMEOUT(8)) dut (.clk(clk), .rst(rst), .b(b));
    always #5 clk = ~clk;
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic request(input logic we, input logic [31:0] a, input logic [31:0] d);
        b.cpu_req   = 1'b1;
        b.cpu_we    = we;
        b.cpu_addr  = a;
        b.cpu_wdata = d;
        step();
        b.cpu_req   = 1'b0;
    endtask
    task automatic test_reset;
        #3;
        tests++; if (b.mobo_ctrl !== 32'h0) begin fails++; $display("FAIL rst_ctrl: got %h exp 0", b.mobo_ctrl); end
        tests++; if (b.addr !== 32'h0) begin fails++; $display("FAIL rst_addr: got %h exp 0", b.addr); end
        tests++; if (b.data_out !== 32'h0) begin fails++; $display("FAIL rst_dout: got %h exp 0", b.data_out); end
        tests++; if (b.cpu_rdata !== 32'h0) begin fails++; $display("FAIL rst_rdata: got %h exp 0", b.cpu_rdata); end
        tests++; if ({b.cpu_busy, b.cpu_done, b.cpu_err} !== 3'b000) begin fails++; $display("FAIL rst_flags: got %b exp 000", {b.cpu_busy, b.cpu_done, b.cpu_err}); end
        #9 rst = 1'b1;
        step();
    endtask
    task automatic test_zero_wait_read;
        request(1'b0, 32'h100, 32'h0);
        tests++; if (b.mobo_ctrl !== 32'h1) begin fails++; $display("FAIL zw_req: got %h exp 1", b.mobo_ctrl); end
        tests++; if (b.addr !== 32'h100) begin fails++; $display("FAIL zw_addr: got %h exp 100", b.addr); end
        tests++; if (b.cpu_busy !== 1'b1) begin fails++; $display("FAIL zw_busy: got %b exp 1", b.cpu_busy); end
        b.mobo_stat = 32'h1;
        b.data_in   = 32'hDEADBEEF;
        step();
        tests++; if (b.mobo_ctrl !== 32'h0) begin fails++; $display("FAIL zw_rel: got %h exp 0", b.mobo_ctrl); end
        tests++; if (b.cpu_done !== 1'b0) begin fails++; $display("FAIL zw_early_done: got %b exp 0", b.cpu_done); end
        b.mobo_stat = 32'h0;
        step();
        tests++; if (b.cpu_done !== 1'b1) begin fails++; $display("FAIL zw_done: got %b exp 1", b.cpu_done); end
        tests++; if (b.cpu_err !== 1'b0) begin fails++; $display("FAIL zw_err: got %b exp 0", b.cpu_err); end
        tests++; if (b.cpu_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL zw_rdata: got %h exp deadbeef", b.cpu_rdata); end
        step();
        tests++; if ({b.cpu_busy, b.cpu_done} !== 2'b00) begin fails++; $display("FAIL zw_idle: got %b exp 00", {b.cpu_busy, b.cpu_done}); end
    endtask
    task automatic test_write_wait;
        request(1'b1, 32'h20, 32'h12345678);
        for (int c = 1; c <= 5; c++) begin
            if (c == 2) begin
                b.cpu_req  = 1'b1;
                b.cpu_addr = 32'h999;
            end
            tests++; if (b.mobo_ctrl !== 32'h3) begin fails++; $display("FAIL wr_ctrl c%0d: got %h exp 3", c, b.mobo_ctrl); end
            tests++; if (b.addr !== 32'h20 || b.data_out !== 32'h12345678) begin fails++; $display("FAIL wr_hold c%0d: got %h/%h exp 20/12345678", c, b.addr, b.data_out); end
            tests++; if (b.cpu_done !== 1'b0) begin fails++; $display("FAIL wr_nodone c%0d: got %b exp 0", c, b.cpu_done); end
            step();
        end
        b.cpu_req   = 1'b0;
        b.mobo_stat = 32'h1;
        b.data_in   = 32'h55555555;
        step();
        tests++; if (b.mobo_ctrl !== 32'h2) begin fails++; $display("FAIL wr_rel: got %h exp 2", b.mobo_ctrl); end
        b.mobo_stat = 32'h0;
        step();
        tests++; if (b.cpu_done !== 1'b1 || b.cpu_err !== 1'b0) begin fails++; $display("FAIL wr_done: got done=%b err=%b exp 1/0", b.cpu_done, b.cpu_err); end
        tests++; if (b.cpu_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_rdata: got %h exp deadbeef", b.cpu_rdata); end
        step();
        tests++; if ({b.cpu_busy, b.cpu_done} !== 2'b00 || b.addr !== 32'h20) begin fails++; $display("FAIL wr_after: got busy/done=%b addr=%h exp 00/20", {b.cpu_busy, b.cpu_done}, b.addr); end
    endtask
    task automatic test_read_err;
        request(1'b0, 32'h44, 32'h0);
        b.mobo_stat = 32'h3;
        b.data_in   = 32'hAAAA5555;
        step();
        b.mobo_stat = 32'h0;
        step();
        tests++; if (b.cpu_done !== 1'b1 || b.cpu_err !== 1'b1) begin fails++; $display("FAIL err_done: got done=%b err=%b exp 1/1", b.cpu_done, b.cpu_err); end
        tests++; if (b.cpu_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL err_rdata: got %h exp deadbeef", b.cpu_rdata); end
        step();
        tests++; if (b.cpu_err !== 1'b1 || b.cpu_done !== 1'b0) begin fails++; $display("FAIL err_hold: got err=%b done=%b exp 1/0", b.cpu_err, b.cpu_done); end
    endtask
    task automatic test_timeout;
        request(1'b0, 32'h300, 32'h0);
        for (int c = 1; c <= 8; c++) begin
            tests++; if (b.mobo_ctrl !== 32'h1 || b.cpu_done !== 1'b0) begin fails++; $display("FAIL to_wait c%0d: got ctrl=%h done=%b exp 1/0", c, b.mobo_ctrl, b.cpu_done); end
            step();
        end
        tests++; if (b.mobo_ctrl !== 32'h0) begin fails++; $display("FAIL to_reqdrop: got %h exp 0", b.mobo_ctrl); end
        tests++; if (b.cpu_done !== 1'b1 || b.cpu_err !== 1'b1) begin fails++; $display("FAIL to_done: got done=%b err=%b exp 1/1", b.cpu_done, b.cpu_err); end
        step();
        tests++; if (b.cpu_busy !== 1'b0 || b.addr !== 32'h300) begin fails++; $display("FAIL to_idle: got busy=%b addr=%h exp 0/300", b.cpu_busy, b.addr); end
        request(1'b0, 32'h400, 32'h0);
        tests++; if (b.mobo_ctrl !== 32'h1 || b.addr !== 32'h400) begin fails++; $display("FAIL to_next_req: got ctrl=%h addr=%h exp 1/400", b.mobo_ctrl, b.addr); end
        b.mobo_stat = 32'h1;
        b.data_in   = 32'h0BADF00D;
        step();
        b.mobo_stat = 32'h0;
        step();
        tests++; if (b.cpu_done !== 1'b1 || b.cpu_err !== 1'b0 || b.cpu_rdata !== 32'h0BADF00D) begin fails++; $display("FAIL to_next_done: got done=%b err=%b rdata=%h exp 1/0/0badf00d", b.cpu_done, b.cpu_err, b.cpu_rdata); end
        step();
    endtask
    task automatic test_reset_mid;
        request(1'b1, 32'h500, 32'hCAFE);
        tests++; if (b.mobo_ctrl !== 32'h3) begin fails++; $display("FAIL rm_req: got %h exp 3", b.mobo_ctrl); end
        #2 rst = 1'b0;
        #1;
        tests++; if (b.mobo_ctrl !== 32'h0) begin fails++; $display("FAIL rm_ctrl: got %h exp 0", b.mobo_ctrl); end
        tests++; if (b.cpu_busy !== 1'b0 || b.cpu_done !== 1'b0) begin fails++; $display("FAIL rm_flags: got busy=%b done=%b exp 0/0", b.cpu_busy, b.cpu_done); end
        tests++; if (b.cpu_rdata !== 32'h0 || b.addr !== 32'h0) begin fails++; $display("FAIL rm_regs: got rdata=%h addr=%h exp 0/0", b.cpu_rdata, b.addr); end
        #2 rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            tests++; if (b.cpu_done !== 1'b0 || b.cpu_busy !== 1'b0 || b.mobo_ctrl !== 32'h0) begin fails++; $display("FAIL rm_quiet c%0d: got done=%b busy=%b ctrl=%h exp 0/0/0", c, b.cpu_done, b.cpu_busy, b.mobo_ctrl); end
        end
    endtask
    task automatic test_back_to_back;
        int n_done = 0;
        b.cpu_req  = 1'b1;
        b.cpu_we   = 1'b0;
        b.cpu_addr = 32'h600;
        for (int c = 0; c < 16; c++) begin
            tests++; if (b.mobo_ctrl[0] !== (c % 4 == 1)) begin fails++; $display("FAIL b2b_req c%0d: got %b exp %b", c, b.mobo_ctrl[0], c % 4 == 1); end
            tests++; if (b.cpu_done !== (c % 4 == 3) || b.cpu_busy !== (c % 4 != 0)) begin fails++; $display("FAIL b2b_flags c%0d: got done=%b busy=%b", c, b.cpu_done, b.cpu_busy); end
            if (b.cpu_done === 1'b1) n_done++;
            b.mobo_stat = {31'h0, b.mobo_ctrl[0]};
            b.data_in   = 32'h1000 + c;
            if (c == 15) b.cpu_req = 1'b0;
            step();
        end
        tests++; if (n_done != 4) begin fails++; $display("FAIL b2b_count: got %0d exp 4", n_done); end
        tests++; if (b.cpu_rdata !== 32'h100D || b.cpu_busy !== 1'b0) begin fails++; $display("FAIL b2b_end: got rdata=%h busy=%b exp 100d/0", b.cpu_rdata, b.cpu_busy); end
    endtask
    initial begin
        b.cpu_req   = 1'b0;
        b.cpu_we    = 1'b0;
        b.cpu_addr  = '0;
        b.cpu_wdata = '0;
        b.mobo_stat = '0;
        b.data_in   = '0;
        test_reset();
        test_zero_wait_read();
        test_write_wait();
        test_read_err();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end
endmodule

// File: doc/bus_iface.md
Name: bus_iface

Overview:
- Memory/IO bus interface unit between the CPU datapath and the motherboard bus.
- Sits directly downstream of the T1/T2/ALU datapath. Takes single-word read/write requests from the CPU control logic and runs a four-phase REQ/ACK handshake on mobo_ctrl/mobo_stat.
- Drives addr/data_out and captures data_in on reads.
- Reports completion, read data and bus error/timeout back to the CPU.

Parameters:
- width, 32, bus and data word width (matches cpu width).
- TIMEOUT, 255, max cycles waited in any handshake phase before abort; legal range 1..65535.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  request strobe, sampled only in IDLE.
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req.
- cpu_addr  in  width  transaction address; sampled with cpu_req.
- cpu_wdata  in  width  write data; sampled with cpu_req.
- cpu_busy  out  1  high whenever state is not IDLE.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_err  out  1  status of the last transaction; valid while cpu_done is high, held until the next completion.
- cpu_rdata  out  width  read data; updated only by a successful read, held otherwise.
- mobo_ctrl  out  width  bit0 = REQ, bit1 = WE, all other bits 0.
- mobo_stat  in  width  bit0 = ACK, bit1 = ERR, other bits ignored.
- addr  out  width  registered bus address.
- data_out  out  width  registered write data.
- data_in  in  width  bus read data, valid while ACK = 1.

Behaviour:
- Reset (rst = 0, async): state IDLE; mobo_ctrl, addr, data_out, cpu_rdata, timeout counter = 0; cpu_busy, cpu_done, cpu_err = 0.
- Reset mid-transaction: REQ drops immediately, without waiting for a clock edge. The transaction is abandoned and no cpu_done is produced.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States: IDLE, ASSERT, RELEASE, DONE.
- IDLE:
  - cpu_req = 1 at an edge latches cpu_addr into addr and cpu_wdata into data_out, and sets mobo_ctrl bit1 = cpu_we and bit0 = 1.
  - Counter cleared; go to ASSERT.
- ASSERT: REQ held at 1. Counter increments each cycle.
  - ACK = 1: REQ <= 0; cpu_err <= ERR bit. If read and ERR = 0, cpu_rdata <= data_in. Counter cleared; go to RELEASE.
  - Counter reaches TIMEOUT-1 with ACK = 0: REQ <= 0; cpu_err <= 1; go to DONE (skip RELEASE).
- RELEASE: REQ = 0. Counter increments.
  - ACK = 0: go to DONE.
  - Counter reaches TIMEOUT-1 with ACK still 1: cpu_err <= 1; go to DONE.
- DONE: cpu_done = 1 for exactly this cycle; mobo_ctrl bit1 cleared; go to IDLE.
- Boundary rules:
  - cpu_req asserted while busy is ignored, not queued.
  - A back-to-back request may be accepted at the edge leaving DONE→IDLE only on the following cycle, so the minimum spacing is 4 cycles per transaction.
- Latency (zero-wait bus, ACK in the first ASSERT cycle, ACK low in the first RELEASE cycle):
  - Edge0 samples req; REQ is high in cycle 1.
  - Edge1 sees ACK; edge2 sees ACK low.
  - cpu_done is high in cycle 3.
- Timeout with no ACK: cpu_done occurs TIMEOUT+1 cycles after the req edge.
- addr and data_out hold their values after completion until the next accepted request.
- Simultaneous ACK and timeout terminal count in ASSERT: ACK wins (normal completion).

Test Plan:
- Zero-wait read: req, we = 0, addr = 0x100; bus returns ACK with data_in = 0xDEADBEEF in cycle 1 and drops it in cycle 2 -> REQ high only in cycle 1; cpu_done in cycle 3; cpu_rdata = 0xDEADBEEF; cpu_err = 0.
- Write with 5 wait states: we = 1, addr = 0x20, wdata = 0x12345678; ACK after 5 cycles -> mobo_ctrl = 0x3 while waiting; addr/data_out stable; cpu_done once; cpu_rdata unchanged.
- ERR on read: ACK with ERR = 1 and data_in = 0xAAAA5555 -> cpu_err = 1; cpu_rdata keeps its previous value.
- Timeout (TIMEOUT = 8, never ACK) -> REQ drops after 8 cycles; cpu_done at cycle 9 with cpu_err = 1; a new request is then accepted normally.
- Reset mid-ASSERT: rst low between edges -> mobo_ctrl = 0 immediately; no cpu_done; cpu_busy = 0.
- cpu_req held high continuously with 4 zero-wait transactions -> one transaction every 4 cycles; requests raised while busy do not add extra transactions.
